// File: rtl/cla_seq_pkg.sv
//----------------------------------------------------------------------
// cla_seq_pkg : shared types and sizing helpers for cla_seq_ctrl
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

package cla_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cla_seq_state_t;

  localparam int CHUNKS_DEF = 4;

  // A counter needs at least one bit even when there is a single chunk.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CNT_W = cnt_width(CHUNKS_DEF);

endpackage

`default_nettype wire

// File: rtl/cla_noseg.sv
//----------------------------------------------------------------------
// cla_noseg : single-segment BITS-wide carry-lookahead adder (parallel prefix)
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module cla_noseg #(
  parameter int BITS = 48
) (
  input  logic [BITS-1:0] a_in,
  input  logic [BITS-1:0] b_in,
  input  logic            c_in,
  output logic [BITS-1:0] sum_out,
  output logic            c_out
);

  localparam int LV = (BITS > 1) ? $clog2(BITS) : 1;

  logic [LV:0][BITS-1:0] gk;
  logic [LV:0][BITS-1:0] pk;
  logic [BITS-1:0]       cy;

  // Carry-in is folded into bit 0's generate so every prefix G is a true carry.
  always_comb begin
    gk = '0;
    pk = '0;
    cy = '0;
    gk[0] = a_in & b_in;
    pk[0] = a_in ^ b_in;
    gk[0][0] = (a_in[0] & b_in[0]) | ((a_in[0] ^ b_in[0]) & c_in);
    for (int l = 0; l < LV; l++) begin
      for (int i = 0; i < BITS; i++) begin
        if (i >= (1 << l)) begin
          gk[l+1][i] = gk[l][i] | (pk[l][i] & gk[l][i-(1<<l)]);
          pk[l+1][i] = pk[l][i] & pk[l][i-(1<<l)];
        end else begin
          gk[l+1][i] = gk[l][i];
          pk[l+1][i] = pk[l][i];
        end
      end
    end
    cy[0] = c_in;
    for (int i = 1; i < BITS; i++) begin
      cy[i] = gk[LV][i-1];
    end
  end

  assign sum_out = pk[0] ^ cy;
  assign c_out   = gk[LV][BITS-1];

endmodule

`default_nettype wire

// File: rtl/cla_seq_ctrl.sv
//----------------------------------------------------------------------
// cla_seq_ctrl : wide add/subtract by time-sharing one CLA chunk, LSB first
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module cla_seq_ctrl
  import cla_seq_pkg::*;
#(
  parameter int BITS   = 48,
  parameter int CHUNKS = 4,
  parameter int W      = BITS * CHUNKS
) (
  input  logic         _clk_in,
  input  logic         _rst_n_in,
  input  logic         _req_valid_in,
  output logic         _req_ready_out,
  input  logic [W-1:0] _op_a_in,
  input  logic [W-1:0] _op_b_in,
  input  logic         _sub_in,
  input  logic         _flush_in,
  output logic         _res_valid_out,
  input  logic         _res_ready_in,
  output logic [W-1:0] _res_out,
  output logic         _carry_out,
  output logic         _ovf_out,
  output logic         _busy_out
);

  localparam int            CW   = cnt_width(CHUNKS);
  localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

  cla_seq_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   res_q, res_d;
  logic           ovf_q, ovf_d;

  logic [BITS-1:0] a_slice, b_slice, sum;
  logic            cla_cout;

  assign a_slice = a_q[cnt_q*BITS +: BITS];
  assign b_slice = b_q[cnt_q*BITS +: BITS];

  cla_noseg #(.BITS(BITS)) u_cla (
    .a_in    (a_slice),
    .b_in    (b_slice),
    .c_in    (carry_q),
    .sum_out (sum),
    .c_out   (cla_cout)
  );

  always_ff @(posedge _clk_in or negedge _rst_n_in) begin
    if (!_rst_n_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next state; flush outranks both acceptance and completion.
  always_comb begin
    state_d = state_q;
    if (_flush_in) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (_req_valid_in) state_d = RUN;
        RUN:     if (cnt_q == LAST) state_d = DONE;
        DONE:    if (_res_ready_in) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    if (_flush_in) begin
      cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (_req_valid_in) begin
            a_d     = _op_a_in;
            b_d     = _sub_in ? ~_op_b_in : _op_b_in;
            carry_d = _sub_in;
            cnt_d   = '0;
          end
        end
        RUN: begin
          res_d[cnt_q*BITS +: BITS] = sum;
          carry_d = cla_cout;
          if (cnt_q == LAST) begin
            ovf_d = (a_q[W-1] == b_q[W-1]) && (sum[BITS-1] != a_q[W-1]);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Result fields are only exposed while a result is on offer.
  always_comb begin
    _req_ready_out = (state_q == IDLE);
    _busy_out      = (state_q != IDLE);
    _res_valid_out = (state_q == DONE);
    _res_out       = (state_q == DONE) ? res_q : '0;
    _carry_out     = (state_q == DONE) ? carry_q : 1'b0;
    _ovf_out       = (state_q == DONE) ? ovf_q : 1'b0;
  end

endmodule

`default_nettype wire

// File: tb/tb_cla_seq_ctrl.sv
//----------------------------------------------------------------------
// tb_cla_seq_ctrl : directed, scoreboard-checked bench for cla_seq_ctrl
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module tb_cla_seq_ctrl;

  localparam int BITS   = 48;
  localparam int CHUNKS = 4;
  localparam int W      = BITS * CHUNKS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready;
  logic [W-1:0] op_a, op_b;
  logic         sub, flush;
  logic         res_valid, res_ready;
  logic [W-1:0] res;
  logic         carry, ovf, busy;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  cla_seq_ctrl #(.BITS(BITS), .CHUNKS(CHUNKS)) dut (
    ._clk_in        (clk),
    ._rst_n_in      (rst_n),
    ._req_valid_in  (req_valid),
    ._req_ready_out (req_ready),
    ._op_a_in       (op_a),
    ._op_b_in       (op_b),
    ._sub_in        (sub),
    ._flush_in      (flush),
    ._res_valid_out (res_valid),
    ._res_ready_in  (res_ready),
    ._res_out       (res),
    ._carry_out     (carry),
    ._ovf_out       (ovf),
    ._busy_out      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: one full-width add, independent of chunking.
  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W-1:0] bb;
    logic [W:0]   full;
    exp_t         e;
    bb     = s ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, s};
    e.res  = full[W-1:0];
    e.c    = full[W];
    e.v    = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int n;
    push_exp(a, b, s);
    req_valid = 1'b1;
    op_a = a;
    op_b = b;
    sub  = s;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", {{(W-1){1'b0}}, req_ready}, {{(W-1){1'b0}}, 1'b1});
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int lat;
    lat = 1;
    while (!res_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, W'(lat), W'(CHUNKS + 1));
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, W'(1), W'(0));
    end else begin
      e = sb.pop_front();
      chk({tag, "_res"},   res, e.res);
      chk({tag, "_carry"}, W'(carry), W'(e.c));
      chk({tag, "_ovf"},   W'(ovf), W'(e.v));
    end
  endtask

  task automatic consume(input string tag);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_valid_drop"}, W'(res_valid), W'(0));
    chk({tag, "_ready_back"}, W'(req_ready), W'(1));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s);
    send(a, b, s);
    wait_result(tag);
    check_result(tag);
    consume(tag);
  endtask

  logic [W-1:0] one, ra, rb;
  exp_t         hold;

  initial begin
    one = {{(W-1){1'b0}}, 1'b1};
    rst_n = 1'b0; req_valid = 1'b0; op_a = '0; op_b = '0; sub = 1'b0;
    flush = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_ready", W'(req_ready), W'(1));
    chk("rst_valid", W'(res_valid), W'(0));
    chk("rst_busy",  W'(busy), W'(0));
    chk("rst_res",   res, '0);

    // Asynchronous reset in the middle of RUN.
    req_valid = 1'b1; op_a = {W{1'b1}}; op_b = one; sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("midrun_busy", W'(busy), W'(1));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", W'(req_ready), W'(1));
    chk("arst_busy",  W'(busy), W'(0));
    chk("arst_valid", W'(res_valid), W'(0));
    chk("arst_res",   res, '0);
    chk("arst_carry", W'(carry), W'(0));
    chk("arst_ovf",   W'(ovf), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("chunk_carry", (one << 48) - one, one, 1'b0);
    run_op("full_wrap",   {W{1'b1}}, one, 1'b0);
    run_op("sub_borrow",  W'(5), W'(7), 1'b1);
    run_op("signed_ovf",  (one << (W-1)) - one, one, 1'b0);
    run_op("sub_ovf",     one << (W-1), one, 1'b1);
    run_op("sub_equal",   W'(12345), W'(12345), 1'b1);
    for (int i = 0; i < 4; i++) begin
      ra = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_op("random", ra, rb, i[0]);
    end

    // Backpressure, then flush racing a consume.
    send({W{1'b1}}, W'(3), 1'b0);
    wait_result("bp");
    hold = sb[0];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", W'(res_valid), W'(1));
      chk("bp_res",   res, hold.res);
      chk("bp_carry", W'(carry), W'(hold.c));
    end
    flush = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    res_ready = 1'b0;
    void'(sb.pop_front());
    chk("flush_valid", W'(res_valid), W'(0));
    chk("flush_busy",  W'(busy), W'(0));
    chk("flush_ready", W'(req_ready), W'(1));
    run_op("post_flush", W'(100), W'(23), 1'b0);

    chk("sb_drained", W'(sb.size()), W'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
